free_list_ctrl: RTL and testbench

Owns the pool of free packet-buffer block indices in shared packet memory. It hands one block index per grant to the allocation arbiter, which serves the per-port memory write controllers in order. It also takes back indices released by the egress memory read path. A reset-time initialisation sequence fills the list before any grant is issued.

---
 rtl/free_list_if.sv | 39 +++
 rtl/free_list_ctrl.sv | 134 +++++++++++++
 tb/tb_free_list_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Allocation/free handshake bundle between free_list_ctrl and its arbiter/egress clients.
// err_double_free_o exists only when FL_DOUBLE_FREE_CHECK_EN is defined.
interface free_list_if #(
  parameter int ADDR_W = 8
);
  logic              alloc_req_i;
  logic              alloc_gnt_o;
  logic [ADDR_W-1:0] alloc_block_idx_o;
  logic              free_req_i;
  logic [ADDR_W-1:0] free_block_idx_i;
  logic              init_done_o;
  logic [ADDR_W:0]   free_count_o;
  logic              empty_o;
`ifdef FL_DOUBLE_FREE_CHECK_EN
  logic              err_double_free_o;

  modport master (
    output alloc_req_i, free_req_i, free_block_idx_i,
    input  alloc_gnt_o, alloc_block_idx_o, init_done_o, free_count_o, empty_o,
           err_double_free_o
  );

  modport slave (
    input  alloc_req_i, free_req_i, free_block_idx_i,
    output alloc_gnt_o, alloc_block_idx_o, init_done_o, free_count_o, empty_o,
           err_double_free_o
  );
`else
  modport master (
    output alloc_req_i, free_req_i, free_block_idx_i,
    input  alloc_gnt_o, alloc_block_idx_o, init_done_o, free_count_o, empty_o
  );

  modport slave (
    input  alloc_req_i, free_req_i, free_block_idx_i,
    output alloc_gnt_o, alloc_block_idx_o, init_done_o, free_count_o, empty_o
  );
`endif
endinterface

// File: rtl/free_list_ctrl.sv
// FIFO free list of packet-buffer block indices, self-initialised after reset.
// Optional double-free detection is enabled by defining FL_DOUBLE_FREE_CHECK_EN.
module free_list_ctrl #(
  parameter int NUM_BLOCKS = 256,
  parameter int ADDR_W     = $clog2(NUM_BLOCKS)
) (
  input logic        clk,
  input logic        rst_n,
  free_list_if.slave fl
);

  typedef enum logic {INIT, READY} state_e;

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(NUM_BLOCKS);
  localparam logic [ADDR_W:0]   ONE_C      = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_BLOCKS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] mem_q [NUM_BLOCKS];
  logic [ADDR_W-1:0] init_cnt_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_d;
  logic              empty_q;
  logic              init_done_q;

  logic              ready;
  logic              gnt;
  logic              push;
  logic              overflow;
  logic              dbl_free;
  logic [ADDR_W-1:0] head_idx;

  assign ready    = (state_q == READY);
  assign head_idx = mem_q[rd_ptr_q];
  assign gnt      = ready & fl.alloc_req_i & (count_q != '0);
  // A full list can still accept a free if a grant frees a slot in the same cycle.
  assign overflow = (count_q == FULL_COUNT) & ~gnt;
  assign push     = ready & fl.free_req_i & ~overflow & ~dbl_free;

  assign fl.alloc_gnt_o       = gnt;
  assign fl.alloc_block_idx_o = init_done_q ? head_idx : '0;
  assign fl.init_done_o       = init_done_q;
  assign fl.free_count_o      = count_q;
  assign fl.empty_o           = empty_q;

  always_comb begin
    count_d = count_q;
    if (gnt && !push) begin
      count_d = count_q - ONE_C;
    end else if (push && !gnt) begin
      count_d = count_q + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + ONE_A;
          if (init_cnt_q == LAST_IDX) begin
            state_q     <= READY;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= FULL_COUNT;
            empty_q     <= 1'b0;
            init_done_q <= 1'b1;
          end
        end
        READY: begin
          if (gnt) rd_ptr_q <= rd_ptr_q + ONE_A;
          if (push) wr_ptr_q <= wr_ptr_q + ONE_A;
          count_q <= count_d;
          empty_q <= (count_d == '0);
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Index storage is plain memory; INIT rewrites every entry so no reset is needed.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem_q[init_cnt_q] <= init_cnt_q;
    end else if (push) begin
      mem_q[wr_ptr_q] <= fl.free_block_idx_i;
    end
  end

`ifdef FL_DOUBLE_FREE_CHECK_EN
  logic [NUM_BLOCKS-1:0] alloc_q;
  logic [NUM_BLOCKS-1:0] alloc_d;
  logic                  err_q;

  assign dbl_free             = ready & fl.free_req_i & ~alloc_q[fl.free_block_idx_i];
  assign fl.err_double_free_o = err_q;

  // Free clears before grant sets, so a same-index collision ends up allocated.
  always_comb begin
    alloc_d = alloc_q;
    if (push) alloc_d[fl.free_block_idx_i] = 1'b0;
    if (gnt) alloc_d[head_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      err_q   <= 1'b0;
    end else if (state_q == INIT) begin
      alloc_q <= '0;
      err_q   <= 1'b0;
    end else begin
      alloc_q <= alloc_d;
      err_q   <= dbl_free;
    end
  end
`else
  assign dbl_free = 1'b0;
`endif

  overflow_free_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(ready && fl.free_req_i && overflow && !dbl_free));

endmodule

// File: tb/tb_free_list_ctrl.sv
// Scoreboard bench for free_list_ctrl: a queue-based model predicts each cycle's outputs
// and grant indices; a monitor process pops and compares them against the DUT.
module tb_free_list_ctrl;
  localparam int N  = 8;
  localparam int AW = 3;

  typedef struct {
    bit gnt;
    bit done;
    int count;
    bit empty;
    bit err;
    bit inInit;
  } status_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  free_list_if #(.ADDR_W(AW)) fl();

  free_list_ctrl #(.NUM_BLOCKS(N), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .fl   (fl)
  );

  int      compared   = 0;
  int      mismatched = 0;
  status_t statusQ[$];
  int      gntQ[$];

  int modelQ[$];
  int outQ[$];
  bit modelDone;
  int initCnt;
  bit allocated[N];
  bit errExp;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    modelQ    = {};
    outQ      = {};
    modelDone = 1'b0;
    initCnt   = 0;
    errExp    = 1'b0;
    foreach (allocated[i]) allocated[i] = 1'b0;
  endtask

  task automatic modelStep(input bit req, input bit free, input int idx, input bit gnt);
    int g;
    bit dbl;
    bit accept;
    req = req;
    if (!modelDone) begin
      initCnt++;
      if (initCnt == N) begin
        for (int i = 0; i < N; i++) modelQ.push_back(i);
        foreach (allocated[i]) allocated[i] = 1'b0;
        modelDone = 1'b1;
      end
      errExp = 1'b0;
      return;
    end
    dbl = 1'b0;
`ifdef FL_DOUBLE_FREE_CHECK_EN
    dbl = free && !allocated[idx];
`endif
    accept = free && !dbl && (modelQ.size() < N || gnt);
    g = 0;
    if (gnt) g = modelQ.pop_front();
    if (accept) begin
      modelQ.push_back(idx);
      allocated[idx] = 1'b0;
    end
    if (gnt) begin
      allocated[g] = 1'b1;
      outQ.push_back(g);
    end
    errExp = dbl;
  endtask

  // Drive one cycle of inputs at the falling edge and record what the model expects.
  task automatic applyStimulus(input bit rst, input bit req, input bit free, input int idx);
    status_t st;
    @(negedge clk);
    rst_n               = !rst;
    fl.alloc_req_i      = req;
    fl.free_req_i       = free;
    fl.free_block_idx_i = AW'(idx);
    if (rst) modelReset();
    st.gnt    = modelDone && req && (modelQ.size() > 0);
    st.done   = modelDone;
    st.count  = modelQ.size();
    st.empty  = (modelQ.size() == 0);
    st.err    = errExp;
    st.inInit = !modelDone;
    statusQ.push_back(st);
    if (st.gnt) gntQ.push_back(modelQ[0]);
    if (!rst) modelStep(req, free, idx, st.gnt);
  endtask

  // Monitor: compare registered/combinational outputs mid-cycle, pop grants as they appear.
  initial begin
    status_t st;
    forever begin
      @(negedge clk);
      #2;
      if (statusQ.size() > 0) begin
        st = statusQ.pop_front();
        checkOutput("alloc_gnt", fl.alloc_gnt_o, st.gnt);
        checkOutput("init_done", fl.init_done_o, st.done);
        checkOutput("free_count", fl.free_count_o, st.count);
        checkOutput("empty", fl.empty_o, st.empty);
`ifdef FL_DOUBLE_FREE_CHECK_EN
        checkOutput("err_double_free", fl.err_double_free_o, st.err);
`endif
        if (st.inInit) checkOutput("idx_during_init", fl.alloc_block_idx_o, 0);
        if (fl.alloc_gnt_o === 1'b1) begin
          if (gntQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_grant: got idx %0d, expected no grant", fl.alloc_block_idx_o);
          end else begin
            checkOutput("grant_idx", fl.alloc_block_idx_o, gntQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int pos;
    bit req;
    bit free;
    fl.alloc_req_i      = 1'b0;
    fl.free_req_i       = 1'b0;
    fl.free_block_idx_i = '0;
    modelReset();

    $display("[TB] init and drain");
    repeat (2) applyStimulus(1, 0, 0, 0);
    repeat (2 * N + 2) applyStimulus(0, 1, 0, 0);

    $display("[TB] free and reuse");
    applyStimulus(0, 0, 1, 5);
    applyStimulus(0, 0, 1, 2);
    repeat (3) applyStimulus(0, 1, 0, 0);

    $display("[TB] simultaneous grant and free");
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 3);
    applyStimulus(0, 0, 1, 7);
    applyStimulus(0, 1, 1, 6);
    repeat (3) applyStimulus(0, 1, 0, 0);

    $display("[TB] empty with same-cycle free");
    applyStimulus(0, 1, 1, 4);
    applyStimulus(0, 1, 0, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 0, 1, 0);
    applyStimulus(0, 0, 1, 1);
    applyStimulus(0, 0, 1, 2);
    applyStimulus(1, 0, 0, 0);
    repeat (N + 3) applyStimulus(0, 1, 0, 0);

    $display("[TB] double free");
    applyStimulus(1, 0, 0, 0);
    repeat (N) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
`ifdef FL_DOUBLE_FREE_CHECK_EN
    applyStimulus(0, 0, 1, 0);
`endif
    repeat (2) applyStimulus(0, 0, 0, 0);

    $display("[TB] random traffic");
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        applyStimulus(1, 0, 0, 0);
        continue;
      end
      req  = ($urandom_range(0, 3) != 0);
      free = 1'b0;
      idx  = 0;
      if (modelQ.size() < N && $urandom_range(0, 1) == 1) begin
        free = 1'b1;
        if (outQ.size() > 0 && $urandom_range(0, 3) != 0) begin
          pos = $urandom_range(0, outQ.size() - 1);
          idx = outQ[pos];
          outQ.delete(pos);
        end else begin
          idx = $urandom_range(0, N - 1);
        end
      end
      applyStimulus(0, req, free, idx);
    end
    applyStimulus(0, 0, 0, 0);

    #4;
    checkOutput("leftover_grants", gntQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
